// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory: FSM encoding, access error codes
// and the access legality check.
package data_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RW    = 2'd1,
        ERR_ALIGN = 2'd2,
        ERR_RANGE = 2'd3
    } err_e;

    // Classify a request; the first matching problem wins, any non-NONE
    // code rejects the access.
    function automatic err_e check_access(input logic        rd,
                                          input logic        wr,
                                          input logic [31:0] addr,
                                          input int unsigned aw);
        logic [31:0] high_bits;
        high_bits = addr >> (aw + 2);
        if (rd && wr)
            return ERR_RW;
        else if (addr[1:0] != 2'b00)
            return ERR_ALIGN;
        else if (high_bits != 32'd0)
            return ERR_RANGE;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word array: one address shared by the synchronous write and
// the registered read. Contents are deliberately not reset.
module dmem_array #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Write on enable, read the addressed word every cycle (read-first).
    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem.sv
// Slow word-addressed data memory on the CPU data port. Each access is
// latched in IDLE, waits WAIT_STATES cycles in BUSY and completes with a
// single-cycle mem_ready (qualified by mem_err) in RESP.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam logic [7:0] WAIT_LOAD = (WAIT_STATES == 0) ? 8'd0 : 8'(WAIT_STATES - 1);

    state_e                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic                    read_q;
    logic                    write_q;
    err_e                    err_q;

    logic                    req;
    logic                    in_resp;
    logic                    arr_we;
    logic [ADDR_WIDTH-1:0]   arr_addr;
    logic [31:0]             arr_rdata;

    assign req     = mem_read | mem_write;
    assign in_resp = (state_q == ST_RESP);

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_STATES == 0) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 8'd0)
                    state_d = ST_RESP;
                else
                    cnt_d = cnt_q - 8'd1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and counter registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request once in IDLE so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= 32'd0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= ERR_NONE;
        end else if (state_q == ST_IDLE && req) begin
            addr_q  <= data_addr[ADDR_WIDTH+1:2];
            wdata_q <= data_wdata;
            read_q  <= mem_read;
            write_q <= mem_write;
            err_q   <= check_access(mem_read, mem_write, data_addr, ADDR_WIDTH);
        end
    end

    // In IDLE the array reads straight from the bus address so that the
    // word is already registered when a zero-wait access lands in RESP.
    assign arr_addr = (state_q == ST_IDLE) ? data_addr[ADDR_WIDTH+1:2] : addr_q;
    assign arr_we   = in_resp && write_q && (err_q == ERR_NONE) && !rst;

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    // Outputs are decoded from registers only; read data is forced to zero
    // except on a successful read response.
    assign mem_ready  = in_resp;
    assign mem_err    = in_resp && (err_q != ERR_NONE);
    assign data_rdata = (in_resp && read_q && (err_q == ERR_NONE)) ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed vector table, reset-abort sequence, random
// accesses against a word-array model (WAIT_STATES=2), and a zero-wait
// back-to-back sequence on a second instance.
module tb_data_mem;
    import data_mem_pkg::*;

    localparam int AW = 8;
    localparam int WS = 2;
    localparam int WORDS = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: two wait states
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
    logic [31:0] data_rdata;
    logic        mem_ready, mem_err;

    data_mem #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
    );

    // Instance B: zero wait states
    logic        b_rst = 1'b1;
    logic        b_read = 1'b0, b_write = 1'b0;
    logic [31:0] b_addr = 32'd0, b_wdata = 32'd0;
    logic [31:0] b_rdata;
    logic        b_ready, b_err;

    data_mem #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(b_rst), .mem_read(b_read), .mem_write(b_write),
        .data_addr(b_addr), .data_wdata(b_wdata),
        .data_rdata(b_rdata), .mem_ready(b_ready), .mem_err(b_err)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: plain word array plus written flags.
    logic [31:0] model_mem [WORDS];
    bit          model_valid [WORDS];

    function automatic bit model_err(bit rd, bit wr, logic [31:0] a);
        return (rd && wr) || (a % 4 != 0) || (a >= 32'(4 * WORDS));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One access on instance A; lat counts edges after the sample edge
    // until mem_ready is seen (-1 if it never appears).
    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic err, output logic [31:0] rdv);
        lat = -1; err = 1'b0; rdv = 32'd0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; data_addr = a; data_wdata = wd;
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            #1;
            if (mem_ready) begin
                lat = k; err = mem_err; rdv = data_rdata;
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic run_op(input string name, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit exp_err, input bit chk_data, input logic [31:0] exp_data);
        int lat; logic err; logic [31:0] rdv;
        access(rd, wr, a, wd, lat, err, rdv);
        $display("txn %s rd=%0b wr=%0b addr=%h wdata=%h lat=%0d err=%0b rdata=%h",
                 name, rd, wr, a, wd, lat, err, rdv);
        check({name, "_lat"}, 32'(lat), 32'(WS));
        check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
        if (chk_data)
            check({name, "_rdata"}, rdv, exp_data);
        if (wr && !exp_err) begin
            model_mem[a / 4]   = wd;
            model_valid[a / 4] = 1'b1;
        end
    endtask

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        bit          chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [11];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          lat, seen;
        logic        err;
        logic [31:0] rdv;
        int          prev;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'd0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'd0,         1'b1, 1'b1, 32'd0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 1'b0, 32'd0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h1111_1111, 1'b1, 1'b0, 32'd0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'd0,         1'b0, 1'b1, 32'h0BAD_F00D};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h2222_2222, 1'b1, 1'b1, 32'd0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'd0,         1'b0, 1'b1, 32'h0BAD_F00D};
        vecs[8]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'd0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'd0,         1'b0, 1'b1, 32'hA5A5_A5A5};
        vecs[10] = '{1'b1, 1'b0, 32'h8000_0000, 32'd0,         1'b1, 1'b1, 32'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, mem_ready}, 32'd0);
        check("reset_err",   {31'd0, mem_err},   32'd0);
        check("reset_rdata", data_rdata,         32'd0);
        @(negedge clk);
        rst = 1'b0; b_rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_err, vecs[i].chk_data, vecs[i].exp_data);

        // Reset during a write in BUSY: write must be dropped, no ready
        run_op("pre_wr", 1'b0, 1'b1, 32'h20, 32'hCAFE_0020, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        mem_write = 1'b1; data_addr = 32'h20; data_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready_in_rst", {31'd0, mem_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0; mem_write = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (mem_ready) seen++;
        end
        $display("txn abort_wr addr=00000020 wdata=12345678 ready_after_abort=%0d", seen);
        check("abort_no_ready", 32'(seen), 32'd0);
        run_op("post_abort_rd", 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, 1'b1, 32'hCAFE_0020);

        // Random accesses against the model
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, wd;
            bit rd, wr, e, chk;
            int sel, mode;
            sel  = $urandom_range(0, 9);
            mode = $urandom_range(0, 9);
            if (sel == 0)
                a = 32'h100 + ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
            else if (sel == 1)
                a = (32'($urandom_range(1, 4095)) << 10) | (32'($urandom_range(0, 255)) << 2);
            else
                a = 32'h100 + $urandom_range(0, 15) * 4;
            rd = (mode == 0) || (mode < 5);
            wr = (mode == 0) || (mode >= 5);
            wd = $urandom;
            e  = model_err(rd, wr, a);
            chk = rd && (e || model_valid[(a / 4) % WORDS]);
            run_op($sformatf("rnd%0d", i), rd, wr, a, wd, e, chk,
                   e ? 32'd0 : model_mem[(a / 4) % WORDS]);
        end

        // Zero-wait instance: requests held high, ready every second cycle
        prev = 0;
        @(negedge clk);
        b_write = 1'b1; b_addr = 32'h0; b_wdata = 32'h1000_0000;
        for (int i = 0; i < 8; i++) begin
            int got;
            got = -1;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                if (b_ready) begin got = cyc; break; end
            end
            $display("txn b2b%0d rd=%0b wr=%0b addr=%h ready_cyc=%0d err=%0b rdata=%h",
                     i, b_read, b_write, b_addr, got, b_err, b_rdata);
            check($sformatf("b2b%0d_ready", i), {31'd0, got >= 0}, 32'd1);
            check($sformatf("b2b%0d_err", i), {31'd0, b_err}, 32'd0);
            if (i > 0)
                check($sformatf("b2b%0d_interval", i), 32'(got - prev), 32'd2);
            if (i >= 4)
                check($sformatf("b2b%0d_rdata", i), b_rdata,
                      32'h1000_0000 + 32'(i - 4) * 32'h0101_0101);
            prev = got;
            if (i + 1 < 4) begin
                b_addr  = 32'(i + 1) * 4;
                b_wdata = 32'h1000_0000 + 32'(i + 1) * 32'h0101_0101;
            end else if (i + 1 < 8) begin
                b_write = 1'b0; b_read = 1'b1;
                b_addr  = 32'(i + 1 - 4) * 4;
            end
        end
        @(negedge clk);
        b_read = 1'b0; b_write = 1'b0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
